// File: rtl/scan_disp_mux.sv
// Time-multiplexed digit-scan display driver with a per-frame input snapshot and hex-to-7-segment decode.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module scan_disp_mux #(
    parameter int N_DIG = 10,
    parameter int DW    = 4,
    parameter int DIV   = 1000,
    localparam int SW   = $clog2(N_DIG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_DIG*DW-1:0]   din,
    output logic [SW-1:0]         sel,
    output logic [DW-1:0]         y,
    output logic [N_DIG-1:0]      an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DCW-1:0]      div_cnt;
    logic [SW-1:0]       idx;
    logic [N_DIG*DW-1:0] snap;
    logic                tick;
    logic                wrap;
    logic [DW-1:0]       cur_dig;
    logic [3:0]          nib;
    logic                cur_blank;
    logic [N_DIG-1:0]    one_hot;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick    = en && (div_cnt == DCW'(DIV - 1));
    assign wrap    = tick && (idx == SW'(N_DIG - 1));
    assign nib     = 4'(cur_dig);
    assign one_hot = N_DIG'(1) << idx;

    always_comb begin
        cur_dig = '0;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx == SW'(k)) cur_dig = snap[k*DW +: DW];
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is blank when it and every more significant digit of the snapshot are zero.
    logic [N_DIG-1:0] blank_mask;
    logic             lz;

    always_comb begin
        blank_mask = '0;
        lz         = 1'b1;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            lz            = lz && (snap[k*DW +: DW] == '0);
            blank_mask[k] = lz;
        end
    end

    assign cur_blank = |(blank_mask & one_hot);
`else
    assign cur_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            snap       <= '0;
            sel        <= '0;
            y          <= '0;
            an         <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (en) begin
                div_cnt <= tick ? '0 : div_cnt + DCW'(1);
                if (tick) idx <= (idx == SW'(N_DIG - 1)) ? '0 : idx + SW'(1);
                if (wrap) snap <= din;
                sel <= idx;
                y   <= cur_dig;
                an  <= cur_blank ? '0 : one_hot;
                seg <= cur_blank ? 7'h00 : hex7(nib);
            end else begin
                y   <= '0;
                an  <= '0;
                seg <= 7'h00;
            end
        end
    end

endmodule
